// File: rtl/sw_db_pkg.sv
// Shared constants for the slide-switch debouncer.
//   CLK_HZ            : frequency of CLK100MHZ
//   ms_to_cycles()    : converts a debounce window in milliseconds to clock cycles
//   DEFAULT_DB_CYCLES : default stability window (10 ms)
package sw_db_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  // Cycles of CLK100MHZ spanning the given number of milliseconds.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int unsigned DEFAULT_DB_CYCLES = ms_to_cycles(10);

endpackage

// File: rtl/sw_debounce_bit.sv
// One-switch conditioner: 2-FF synchronizer followed by a stability counter.
//   CLK100MHZ  : clock
//   CPU_RESETN : async active-low reset
//   sw_raw     : raw switch level, asynchronous, may bounce
//   db         : debounced level (registered)
//   rise/fall  : one-cycle pulses coinciding with a db update (registered)
//   accept_c   : combinational, high in the cycle before db updates
module sw_debounce_bit
  import sw_db_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic sw_raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic accept_c
);

  localparam int unsigned     CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          db_nxt;
  logic          rise_nxt;
  logic          fall_nxt;

  // Count consecutive cycles where the synchronized level differs from db;
  // any return to the current level clears the count.
  always_comb begin
    cnt_nxt  = '0;
    db_nxt   = db;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    accept_c = 1'b0;
    if (s2 != db) begin
      if (cnt == CNT_MAX) begin
        db_nxt   = s2;
        accept_c = 1'b1;
        rise_nxt = s2;
        fall_nxt = ~s2;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Synchronizer, counter and output registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= sw_raw;
      s2   <= s1;
      cnt  <= cnt_nxt;
      db   <= db_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

endmodule

// File: rtl/sw_debouncer.sv
// Debounces the N_SW raw slide switches into clean levels plus edge pulses.
//   CLK100MHZ  : clock
//   CPU_RESETN : async active-low reset
//   SW         : raw switch inputs
//   SW_DB      : debounced levels
//   SW_RISE    : per-bit 0->1 pulses
//   SW_FALL    : per-bit 1->0 pulses
//   SW_CHANGED : any pulse this cycle
module sw_debouncer
  import sw_db_pkg::*;
#(
  parameter int unsigned N_SW      = 16,
  parameter int unsigned DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic            CLK100MHZ,
  input  logic            CPU_RESETN,
  input  logic [N_SW-1:0] SW,
  output logic [N_SW-1:0] SW_DB,
  output logic [N_SW-1:0] SW_RISE,
  output logic [N_SW-1:0] SW_FALL,
  output logic            SW_CHANGED
);

  logic [N_SW-1:0] accept;

  // One independent conditioner per switch.
  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    sw_debounce_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_bit (
      .CLK100MHZ  (CLK100MHZ),
      .CPU_RESETN (CPU_RESETN),
      .sw_raw     (SW[i]),
      .db         (SW_DB[i]),
      .rise       (SW_RISE[i]),
      .fall       (SW_FALL[i]),
      .accept_c   (accept[i])
    );
  end

  // Built from the per-bit accept terms so it lands in the same cycle as the pulses.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      SW_CHANGED <= 1'b0;
    end else begin
      SW_CHANGED <= |accept;
    end
  end

endmodule

// File: tb/tb_sw_debouncer.sv
module tb_sw_debouncer;

  localparam int unsigned N_SW = 16;
  localparam int unsigned DB   = 8;

  logic            clk;
  logic            rst_n;
  logic [N_SW-1:0] sw;
  logic [N_SW-1:0] sw_db;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;
  logic            sw_changed;

  sw_debouncer #(
    .N_SW      (N_SW),
    .DB_CYCLES (DB)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .SW         (sw),
    .SW_DB      (sw_db),
    .SW_RISE    (sw_rise),
    .SW_FALL    (sw_fall),
    .SW_CHANGED (sw_changed)
  );

  typedef struct {
    int unsigned     cyc;
    logic [N_SW-1:0] db;
    logic [N_SW-1:0] rise;
    logic [N_SW-1:0] fall;
  } ev_t;

  ev_t             exp_q[$];
  ev_t             mon_ev;
  logic [N_SW-1:0] model_db;
  int unsigned     cyc;
  int unsigned     n_vec;
  int unsigned     n_err;
  int unsigned     c0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int unsigned c, input logic [N_SW-1:0] db,
                           input logic [N_SW-1:0] rise, input logic [N_SW-1:0] fall);
    ev_t e;
    e.cyc  = c;
    e.db   = db;
    e.rise = rise;
    e.fall = fall;
    exp_q.push_back(e);
  endtask

  // Monitor: sample 1 time unit after each edge; pop an expected event whenever the DUT pulses.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      model_db = '0;
    end else if (sw_rise != '0 || sw_fall != '0 || sw_changed) begin
      if (exp_q.size() == 0) begin
        n_vec = n_vec + 1;
        n_err = n_err + 1;
        $display("FAIL unexpected_pulse: rise=%h fall=%h changed=%b, expected no pulse (cycle %0d)",
                 sw_rise, sw_fall, sw_changed, cyc);
      end else begin
        mon_ev = exp_q.pop_front();
        check("event_cycle", 32'(cyc), 32'(mon_ev.cyc));
        check("event_db", 32'(sw_db), 32'(mon_ev.db));
        check("event_rise", 32'(sw_rise), 32'(mon_ev.rise));
        check("event_fall", 32'(sw_fall), 32'(mon_ev.fall));
        check("event_changed", 32'(sw_changed), 32'd1);
        model_db = mon_ev.db;
      end
    end else begin
      check("db_hold", 32'(sw_db), 32'(model_db));
    end
  end

  initial begin
    n_vec    = 0;
    n_err    = 0;
    model_db = '0;
    rst_n    = 1'b0;
    sw       = 16'hFFFF;

    // 1: reset with all switches high, then release
    repeat (3) @(negedge clk);
    check("reset_db", 32'(sw_db), 32'd0);
    check("reset_rise", 32'(sw_rise), 32'd0);
    check("reset_fall", 32'(sw_fall), 32'd0);
    check("reset_changed", 32'(sw_changed), 32'd0);
    rst_n = 1'b1;
    c0 = cyc;
    expect_ev(c0 + 10, 16'hFFFF, 16'hFFFF, 16'h0000);
    repeat (12) @(negedge clk);

    // return all switches low
    sw = 16'h0000;
    c0 = cyc;
    expect_ev(c0 + 10, 16'h0000, 16'h0000, 16'hFFFF);
    repeat (12) @(negedge clk);

    // 2: clean step on bit 3
    sw[3] = 1'b1;
    c0 = cyc;
    expect_ev(c0 + 10, 16'h0008, 16'h0008, 16'h0000);
    repeat (12) @(negedge clk);

    // 3: bounce on bit 5, 3-cycle runs, then settle high
    for (int k = 0; k < 4; k++) begin
      sw[5] = (k % 2 == 0);
      repeat (3) @(negedge clk);
    end
    sw[5] = 1'b1;
    c0 = cyc;
    expect_ev(c0 + 10, 16'h0028, 16'h0020, 16'h0000);
    repeat (12) @(negedge clk);

    // 4: 7-cycle glitch rejected, 8-cycle pulse accepted (and its release later)
    sw[0] = 1'b1;
    repeat (7) @(negedge clk);
    sw[0] = 1'b0;
    repeat (12) @(negedge clk);
    sw[0] = 1'b1;
    c0 = cyc;
    repeat (8) @(negedge clk);
    sw[0] = 1'b0;
    expect_ev(c0 + 10, 16'h0029, 16'h0001, 16'h0000);
    expect_ev(c0 + 18, 16'h0028, 16'h0000, 16'h0001);
    repeat (20) @(negedge clk);

    // 5: multi-bit transitions in one cycle
    sw = 16'h00F0;
    c0 = cyc;
    expect_ev(c0 + 10, 16'h00F0, 16'h00D0, 16'h0008);
    repeat (12) @(negedge clk);
    sw = 16'h0F00;
    c0 = cyc;
    expect_ev(c0 + 10, 16'h0F00, 16'h0F00, 16'h00F0);
    repeat (12) @(negedge clk);

    // 6: async reset while bit 2 is mid-count
    sw = 16'h0F04;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_db", 32'(sw_db), 32'd0);
    check("async_reset_rise", 32'(sw_rise), 32'd0);
    check("async_reset_changed", 32'(sw_changed), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    expect_ev(c0 + 10, 16'h0F04, 16'h0F04, 16'h0000);
    repeat (14) @(negedge clk);

    check("pending_events", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
